ysyx_210544_wb_queue: RTL
=========================

Name: ysyx_210544_wb_queue

Overview:
Parametrised writeback stage between the memory stage and the commit/regfile-write path. It replaces the single-entry always-ready register with a DEPTH-entry in-order queue that applies real backpressure. It also adds flush, x0-write suppression and occupancy reporting. Entry payload is pc, inst, rd, rd_wen, rd_wdata, skipcmt and intrNo; outputs are zeroed whenever the queue is empty.

Parameters:
XLEN, 64, width of pc and rd_wdata
ILEN, 32, width of inst and intrNo
RIDX, 5, register index width
DEPTH, 2, queue entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
i_wb_flush  in  1  discard all queued entries
i_wb_memoryed_req  in  1  upstream entry valid
o_wb_memoryed_ack  out  1  queue can accept an entry (not full)
i_wb_pc  in  XLEN  instruction pc
i_wb_inst  in  ILEN  instruction word
i_wb_rd  in  RIDX  destination register
i_wb_rd_wen  in  1  register write enable
i_wb_rd_wdata  in  XLEN  register write data
i_wb_skipcmt  in  1  skip difftest commit
i_wb_intrNo  in  ILEN  interrupt number (0 = none)
o_wb_writebacked_req  out  1  head entry valid (not empty)
i_wb_writebacked_ack  in  1  downstream consumes the head entry
o_wb_pc  out  XLEN  head pc
o_wb_inst  out  ILEN  head inst
o_wb_rd  out  RIDX  head rd
o_wb_rd_wen  out  1  head write enable, x0-suppressed
o_wb_rd_wdata  out  XLEN  head write data
o_wb_skipcmt  out  1  head skipcmt
o_wb_intrNo  out  ILEN  head intrNo
o_wb_count  out  CNT_W  current occupancy

Behaviour:
- Reset (rst=1 at posedge): wr_ptr, rd_ptr and count go to 0. The next cycle shows memoryed_ack=1, writebacked_req=0, count=0 and all payload outputs 0. Storage contents are don't-care. Reset mid-operation discards everything.
- o_wb_memoryed_ack = (count != DEPTH); combinational from count only, with no dependency on i_wb_writebacked_ack (no pass-through when full).
- push = i_wb_memoryed_req & o_wb_memoryed_ack & !i_wb_flush; pop = o_wb_writebacked_req & i_wb_writebacked_ack.
- o_wb_writebacked_req = (count != 0).
- Latency: an entry pushed at edge N appears at the head from cycle N+1 (registered storage, no bypass).
- Push writes the entry at wr_ptr and increments wr_ptr mod DEPTH. Pop increments rd_ptr mod DEPTH. Pointers wrap naturally at DEPTH.
- count: push only +1; pop only -1; push and pop together leaves count unchanged, with both pointers advancing. Push and pop together is legal at any occupancy between 1 and DEPTH-1. At count=DEPTH push is blocked, so a pop alone applies.
- Flush: at the next edge, pointers and count are cleared. Flush overrides any same-cycle push and pop. Flush and rst are equivalent in effect on the queue.
- Payload outputs come from the head entry when count != 0, otherwise all zero; this includes intrNo.
- x0 suppression: o_wb_rd_wen = head.rd_wen & (head.rd != 0). rd itself is passed unchanged.
- Order is strict FIFO; no reordering or dropping except by flush/reset.
- Holding writebacked_ack high while empty has no effect, and count never underflows.

Decomposition:
- Shared defines header: BUS_64, BUS_32, BUS_RIDX and a WB entry-width constant (XLEN+ILEN+RIDX+1+XLEN+1+ILEN).
- Sub-module ysyx_210544_wb_fifo: a generic WIDTH×DEPTH synchronous FIFO with push, pop, flush, full, empty and count.
- ysyx_210544_wb_queue packs and unpacks the entry and adds output zeroing and x0 suppression.

Test Plan:
- Reset, then idle -> memoryed_ack=1, writebacked_req=0, count=0, all outputs 0.
- DEPTH=2, downstream ack=0; push pc=0x80000000 then 0x80000004 -> count=2 and memoryed_ack=0. A third req is held and not accepted. Raise ack -> pcs pop in order 0x80000000, 0x80000004.
- Continuous push and ack every cycle, 8 entries -> count stays 1 after the first. The output sequence is identical to the input sequence, and wrap-around is exercised.
- Push rd=0, rd_wen=1, wdata=0x1234 -> o_wb_rd_wen=0, o_wb_rd=0, o_wb_rd_wdata=0x1234.
- count=2, then flush asserted together with req and ack -> next cycle count=0, writebacked_req=0 and outputs 0. The flushed-cycle push is absent.
- Push intrNo=7, pop it, queue goes empty -> o_wb_intrNo=7 while at the head, then 0.

Source files
------------

// File: rtl/ysyx_210544_wb_queue_pkg.sv
// Shared widths for the writeback queue.
//   BUS_64 / BUS_32 / BUS_RIDX : default datapath, instruction and register-index widths
//   WB_ENTRY_W                 : packed entry width at the default widths
//   wb_entry_w()               : packed entry width for arbitrary widths
//                                (pc + inst + rd + rd_wen + rd_wdata + skipcmt + intrNo)
package ysyx_210544_wb_queue_pkg;

    localparam int BUS_64   = 64;
    localparam int BUS_32   = 32;
    localparam int BUS_RIDX = 5;

    function automatic int wb_entry_w(input int xlen, input int ilen, input int ridx);
        return xlen + ilen + ridx + 1 + xlen + 1 + ilen;
    endfunction

    localparam int WB_ENTRY_W = BUS_64 + BUS_32 + BUS_RIDX + 1 + BUS_64 + 1 + BUS_32;

endpackage

// File: rtl/ysyx_210544_wb_fifo.sv
// Generic WIDTH x DEPTH synchronous FIFO, registered storage, no bypass.
//   clk, rst  : clock, synchronous active-high reset
//   flush_i   : clears pointers and count; overrides push/pop
//   push_i    : write data_i (ignored when full)
//   pop_i     : drop head entry (ignored when empty)
//   data_o    : head entry (content undefined when empty)
//   full_o, empty_o, count_o : occupancy status
module ysyx_210544_wb_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push = push_i & ~full_o & ~flush_i;
    assign pop  = pop_i & ~empty_o & ~flush_i;

    // DEPTH is a power of two, so pointer overflow is the mod-DEPTH wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; contents are only observed while count != 0.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ysyx_210544_wb_queue.sv
// Writeback queue between memory stage and commit/regfile write.
// DEPTH-entry in-order queue with real backpressure, flush, x0-write
// suppression and occupancy reporting.
//   i_wb_memoryed_req / o_wb_memoryed_ack     : upstream handshake (ack = not full)
//   o_wb_writebacked_req / i_wb_writebacked_ack : downstream handshake (req = not empty)
//   i_wb_flush : discard all entries at the next edge
//   i_wb_* / o_wb_* payload : pc, inst, rd, rd_wen, rd_wdata, skipcmt, intrNo
//   o_wb_count : current occupancy
module ysyx_210544_wb_queue
    import ysyx_210544_wb_queue_pkg::*;
#(
    parameter  int XLEN  = BUS_64,
    parameter  int ILEN  = BUS_32,
    parameter  int RIDX  = BUS_RIDX,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wb_flush,
    input  logic             i_wb_memoryed_req,
    output logic             o_wb_memoryed_ack,
    input  logic [XLEN-1:0]  i_wb_pc,
    input  logic [ILEN-1:0]  i_wb_inst,
    input  logic [RIDX-1:0]  i_wb_rd,
    input  logic             i_wb_rd_wen,
    input  logic [XLEN-1:0]  i_wb_rd_wdata,
    input  logic             i_wb_skipcmt,
    input  logic [ILEN-1:0]  i_wb_intrNo,
    output logic             o_wb_writebacked_req,
    input  logic             i_wb_writebacked_ack,
    output logic [XLEN-1:0]  o_wb_pc,
    output logic [ILEN-1:0]  o_wb_inst,
    output logic [RIDX-1:0]  o_wb_rd,
    output logic             o_wb_rd_wen,
    output logic [XLEN-1:0]  o_wb_rd_wdata,
    output logic             o_wb_skipcmt,
    output logic [ILEN-1:0]  o_wb_intrNo,
    output logic [CNT_W-1:0] o_wb_count
);

    localparam int ENTRY_W = wb_entry_w(XLEN, ILEN, RIDX);

    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    logic [XLEN-1:0] head_pc;
    logic [ILEN-1:0] head_inst;
    logic [RIDX-1:0] head_rd;
    logic            head_wen;
    logic [XLEN-1:0] head_wdata;
    logic            head_skipcmt;
    logic [ILEN-1:0] head_intr;

    // Ack depends only on occupancy: a full queue never passes through,
    // even if the head is being consumed this cycle.
    assign o_wb_memoryed_ack    = ~full;
    assign o_wb_writebacked_req = ~empty;

    assign push = i_wb_memoryed_req & o_wb_memoryed_ack & ~i_wb_flush;
    assign pop  = o_wb_writebacked_req & i_wb_writebacked_ack;

    assign in_entry = {i_wb_pc, i_wb_inst, i_wb_rd, i_wb_rd_wen,
                       i_wb_rd_wdata, i_wb_skipcmt, i_wb_intrNo};

    ysyx_210544_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (i_wb_flush),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (in_entry),
        .data_o  (head_entry),
        .full_o  (full),
        .empty_o (empty),
        .count_o (o_wb_count)
    );

    assign {head_pc, head_inst, head_rd, head_wen,
            head_wdata, head_skipcmt, head_intr} = head_entry;

    // Stale storage must never leak out, so every payload field is gated.
    assign o_wb_pc       = empty ? '0 : head_pc;
    assign o_wb_inst     = empty ? '0 : head_inst;
    assign o_wb_rd       = empty ? '0 : head_rd;
    assign o_wb_rd_wdata = empty ? '0 : head_wdata;
    assign o_wb_skipcmt  = ~empty & head_skipcmt;
    assign o_wb_intrNo   = empty ? '0 : head_intr;
    assign o_wb_rd_wen   = ~empty & head_wen & (head_rd != '0);

endmodule
